// File: rtl/face_box_locator.sv
// Skin-mask bounding-box locator: tracks pixel coordinates, accumulates
// the skin extent per frame and publishes it at each frame boundary.
module face_box_locator #(
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int CW      = 10,
  parameter int MIN_PIX = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          per_frame_vsync,
  input  logic          per_frame_href,
  input  logic          per_frame_clken,
  input  logic          per_img_bit,
  output logic          post_frame_vsync,
  output logic          post_frame_href,
  output logic          post_frame_clken,
  output logic          post_img_bit,
  output logic [CW-1:0] box_x_min,
  output logic [CW-1:0] box_x_max,
  output logic [CW-1:0] box_y_min,
  output logic [CW-1:0] box_y_max,
  output logic          box_valid,
  output logic          box_update
);

  localparam logic [CW-1:0] X_LAST  = CW'(IMG_W - 1);
  localparam logic [CW-1:0] Y_LAST  = CW'(IMG_H - 1);
  localparam logic [19:0]   MIN_CNT = 20'(MIN_PIX);

  typedef enum logic [1:0] {
    WAIT_FRAME,
    ACCUM,
    LATCH
  } state_t;

  state_t state, state_nx;

  logic          vsync_d;
  logic          href_d;
  logic          vs_rise;
  logic          href_fall;
  logic          pix;
  logic          skin;
  logic          acc_clr;
  logic          acc_en;
  logic          do_latch;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic [CW-1:0] xmin;
  logic [CW-1:0] xmax;
  logic [CW-1:0] ymin;
  logic [CW-1:0] ymax;
  logic [19:0]   pix_cnt;

  assign vs_rise   = per_frame_vsync & ~vsync_d;
  assign href_fall = ~per_frame_href & href_d;
  assign pix       = per_frame_clken & per_frame_href;
  assign skin      = pix & per_img_bit;

  assign post_frame_vsync = vsync_d;
  assign post_frame_href  = href_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d          <= 1'b0;
      href_d           <= 1'b0;
      post_frame_clken <= 1'b0;
      post_img_bit     <= 1'b0;
    end else begin
      vsync_d          <= per_frame_vsync;
      href_d           <= per_frame_href;
      post_frame_clken <= per_frame_clken;
      post_img_bit     <= per_img_bit & per_frame_href;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WAIT_FRAME;
    else        state <= state_nx;
  end

  // The first frame after reset is partial, so it is never accumulated.
  always_comb begin
    state_nx = state;
    acc_clr  = 1'b0;
    acc_en   = 1'b0;
    do_latch = 1'b0;
    unique case (state)
      WAIT_FRAME: begin
        if (vs_rise) begin
          acc_clr  = 1'b1;
          state_nx = ACCUM;
        end
      end
      ACCUM: begin
        if (vs_rise) state_nx = LATCH;
        else         acc_en   = skin;
      end
      LATCH: begin
        do_latch = 1'b1;
        acc_clr  = 1'b1;
        state_nx = ACCUM;
      end
      default: state_nx = WAIT_FRAME;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else begin
      if (vs_rise || do_latch || href_fall) x <= '0;
      else if (pix && x != X_LAST)          x <= x + 1'b1;
      if (vs_rise || do_latch)              y <= '0;
      else if (href_fall && y != Y_LAST)    y <= y + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xmin    <= '0;
      xmax    <= '0;
      ymin    <= '0;
      ymax    <= '0;
      pix_cnt <= '0;
    end else if (acc_clr) begin
      xmin    <= '1;
      xmax    <= '0;
      ymin    <= '1;
      ymax    <= '0;
      pix_cnt <= '0;
    end else if (acc_en) begin
      if (x < xmin) xmin <= x;
      if (x > xmax) xmax <= x;
      if (y < ymin) ymin <= y;
      if (y > ymax) ymax <= y;
      if (pix_cnt != '1) pix_cnt <= pix_cnt + 1'b1;
    end
  end

  // A sparse frame keeps the previous box but flags it as stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      box_x_min  <= '0;
      box_x_max  <= '0;
      box_y_min  <= '0;
      box_y_max  <= '0;
      box_valid  <= 1'b0;
      box_update <= 1'b0;
    end else begin
      box_update <= do_latch;
      if (do_latch) begin
        if (pix_cnt >= MIN_CNT) begin
          box_x_min <= xmin;
          box_x_max <= xmax;
          box_y_min <= ymin;
          box_y_max <= ymax;
          box_valid <= 1'b1;
        end else begin
          box_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_face_box_locator.sv
// Self-checking bench for face_box_locator on a 16x8 image, MIN_PIX=4.
// Frames come from a mask table; box updates are checked via a queue.
module tb_face_box_locator;

  typedef struct packed {
    logic       vld;
    logic [9:0] x0;
    logic [9:0] x1;
    logic [9:0] y0;
    logic [9:0] y1;
  } exp_t;

  typedef struct packed {
    logic [7:0][15:0] mask;
    logic             hot;
    exp_t             exp;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       vsync;
  logic       href;
  logic       clken;
  logic       img;
  logic       pv;
  logic       ph;
  logic       pc;
  logic       pb;
  logic [9:0] bx0;
  logic [9:0] bx1;
  logic [9:0] by0;
  logic [9:0] by1;
  logic       bv;
  logic       bu;

  int   n_chk;
  int   n_pass;
  exp_t q[$];
  vec_t tbl[3];

  face_box_locator #(
    .IMG_W(16), .IMG_H(8), .CW(10), .MIN_PIX(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .per_frame_vsync(vsync), .per_frame_href(href),
    .per_frame_clken(clken), .per_img_bit(img),
    .post_frame_vsync(pv), .post_frame_href(ph),
    .post_frame_clken(pc), .post_img_bit(pb),
    .box_x_min(bx0), .box_x_max(bx1),
    .box_y_min(by0), .box_y_max(by1),
    .box_valid(bv), .box_update(bu)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Input capture at the edge for the 1-clk pass-through check
  logic p_ok, p_vs, p_hr, p_ck, p_bt;
  always @(posedge clk) begin
    p_ok <= rst_n;
    p_vs <= vsync;
    p_hr <= href;
    p_ck <= clken;
    p_bt <= img;
  end

  exp_t held;
  logic prev_upd;
  always @(negedge clk) begin
    if (!rst_n) begin
      held     = '0;
      prev_upd = 1'b0;
    end else begin
      if (p_ok)
        check("pass", {pv, ph, pc, pb},
              {p_vs, p_hr, p_ck, p_bt & p_hr});
      if (prev_upd) check("upd_width", bu, 1'b0);
      if (bu) begin
        if (q.size() == 0) begin
          check("unexp_update", 1'b1, 1'b0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("box_valid", bv, e.vld);
          check("box_x_min", bx0, e.x0);
          check("box_x_max", bx1, e.x1);
          check("box_y_min", by0, e.y0);
          check("box_y_max", by1, e.y1);
        end
        held = {bv, bx0, bx1, by0, by1};
      end else begin
        check("box_hold", {bv, bx0, bx1, by0, by1}, held);
      end
      prev_upd = bu;
    end
  end

  task automatic drive_line(input int n, input logic [63:0] ck,
                            input logic [63:0] bt);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      href  = 1'b1;
      clken = ck[c];
      img   = bt[c];
    end
    // strobes and mask without href in the blanking gap
    repeat (2) begin
      @(negedge clk);
      href  = 1'b0;
      clken = 1'b1;
      img   = 1'b1;
    end
  endtask

  task automatic drive_vsync(input logic hot);
    @(negedge clk);
    vsync = 1'b1;
    href  = hot;
    clken = hot;
    img   = hot;
    @(negedge clk);
    href  = 1'b0;
    clken = 1'b0;
    img   = 1'b0;
    repeat (3) begin
      @(negedge clk);
      vsync = 1'b0;
    end
  endtask

  task automatic drive_frame(input logic [7:0][15:0] m);
    for (int r = 0; r < 8; r++)
      drive_line(16, 64'hFFFF, {48'b0, m[r]});
  endtask

  function automatic exp_t mk(input logic v, input int a, input int b,
                              input int c, input int d);
    exp_t e;
    e.vld = v;
    e.x0  = 10'(a);
    e.x1  = 10'(b);
    e.y0  = 10'(c);
    e.y1  = 10'(d);
    return e;
  endfunction

  logic [7:0][15:0] rect;
  logic [63:0]      bits;

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    vsync  = 1'b0;
    href   = 1'b0;
    clken  = 1'b0;
    img    = 1'b0;

    rect    = '0;
    rect[2] = 16'h0038;
    rect[3] = 16'h0038;
    rect[4] = 16'h0038;

    tbl[0].mask = rect;
    tbl[0].hot  = 1'b0;
    tbl[0].exp  = mk(1'b1, 3, 5, 2, 4);
    tbl[1].mask    = '0;
    tbl[1].mask[0] = 16'h0001;
    tbl[1].mask[7] = 16'h8000;
    tbl[1].mask[4] = 16'h0100;
    tbl[1].hot     = 1'b1;
    tbl[1].exp     = mk(1'b0, 3, 5, 2, 4);
    tbl[2].mask    = '0;
    tbl[2].mask[0] = 16'h8001;
    tbl[2].mask[7] = 16'h8001;
    tbl[2].hot     = 1'b0;
    tbl[2].exp     = mk(1'b1, 0, 15, 0, 7);

    repeat (2) @(negedge clk);
    #1;
    check("rst_box", {bv, bu, bx0, bx1, by0, by1}, '0);
    check("rst_post", {pv, ph, pc, pb}, '0);
    #2 rst_n = 1'b1;

    // first frame after reset is discarded
    drive_frame(rect);
    drive_vsync(1'b0);

    for (int i = 0; i < 3; i++) begin
      drive_frame(tbl[i].mask);
      q.push_back(tbl[i].exp);
      drive_vsync(tbl[i].hot);
    end

    // skin only on un-strobed cycles
    for (int r = 0; r < 8; r++)
      drive_line(32, 64'h5555_5555, 64'hAAAA_AAAA);
    q.push_back(mk(1'b0, 0, 15, 0, 7));
    drive_vsync(1'b0);

    // skin at strobe #6 on lines 1..4
    for (int r = 0; r < 8; r++) begin
      bits = 64'hAAAA_AAAA;
      if (r >= 1 && r <= 4) bits[12] = 1'b1;
      drive_line(32, 64'h5555_5555, bits);
    end
    q.push_back(mk(1'b1, 6, 6, 1, 4));
    drive_vsync(1'b0);

    // 20-pixel lines, 10 lines: both coordinates clamp
    for (int r = 0; r < 10; r++) begin
      bits = '0;
      if (r == 2 || r == 3) bits[19] = 1'b1;
      if (r == 9) begin
        bits[5]  = 1'b1;
        bits[19] = 1'b1;
      end
      drive_line(20, 64'hF_FFFF, bits);
    end
    q.push_back(mk(1'b1, 5, 15, 2, 7));
    drive_vsync(1'b0);

    // mid-frame asynchronous reset
    drive_line(16, 64'hFFFF, 64'hFFFF);
    @(negedge clk);
    href  = 1'b1;
    clken = 1'b1;
    img   = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_box", {bv, bu, bx0, bx1, by0, by1}, '0);
    check("mid_rst_post", {pv, ph, pc, pb}, '0);
    @(negedge clk);
    #3 rst_n = 1'b1;
    drive_line(16, 64'hFFFF, 64'hFFFF);
    drive_line(16, 64'hFFFF, 64'hFFFF);
    drive_vsync(1'b0);
    drive_frame(rect);
    q.push_back(mk(1'b1, 3, 5, 2, 4));
    drive_vsync(1'b0);

    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
    check("drain", 64'(q.size()), 64'd0);
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
